// File: rtl/ice51_uart_loader_pkg.sv
// Shared RX state encodings and default bit timing for ice51 serial blocks.
// Used by ice51_uart_rx and ice51_uart_loader.
package ice51_uart_loader_pkg;

  localparam int DEF_CLKS_PER_BIT = 104;

  localparam logic [2:0] RX_IDLE    = 3'd0;
  localparam logic [2:0] RX_START   = 3'd1;
  localparam logic [2:0] RX_DATA    = 3'd2;
  localparam logic [2:0] RX_STOP    = 3'd3;
  localparam logic [2:0] RX_WAIT_HI = 3'd4;

endpackage

// File: rtl/ice51_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, shift register.
// Emits a one-cycle byte-valid or frame-error pulse per frame.
module ice51_uart_rx
  import ice51_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic          r_s1;
  logic          r_s2;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_sr;
  logic          r_valid;
  logic          r_ferr;
  logic          w_rx;

  assign w_rx        = r_s2;
  assign o_valid     = r_valid;
  assign o_data      = r_sr;
  assign o_frame_err = r_ferr;

  always_ff @(posedge i_clk or posedge i_nrst) begin
    if (i_nrst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_rx;
      r_s2 <= r_s1;
    end
  end

  // STOP returns to IDLE at mid-stop-bit so a zero-gap start edge is caught
  always_ff @(posedge i_clk or posedge i_nrst) begin
    if (i_nrst) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sr    <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (!w_rx) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == HALF) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL) begin
            r_cnt <= '0;
            r_sr  <= {w_rx, r_sr[7:1]};
            r_bit <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL) begin
            r_cnt <= '0;
            if (w_rx) begin
              r_valid <= 1'b1;
              r_state <= RX_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= RX_WAIT_HI;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_WAIT_HI: begin
          if (w_rx) r_state <= RX_IDLE;
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ice51_uart_loader.sv
// Serial boot loader: writes received UART bytes into code memory 0..MEM_SIZE-1.
// ICE51_LOADER_BYPASS_EN: skip the loader, o_done high right after reset.
module ice51_uart_loader
  import ice51_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int MEM_SIZE     = 1024,
  parameter int ADDR_W       = 10
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_uart_rx,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_done,
  output logic              o_frame_err
);

`ifdef ICE51_LOADER_BYPASS_EN

  logic r_done;
  logic w_unused;

  assign w_unused    = i_uart_rx;
  assign o_mem_we    = 1'b0;
  assign o_mem_addr  = '0;
  assign o_mem_wdata = 8'h00;
  assign o_frame_err = 1'b0;
  assign o_done      = r_done;

  always_ff @(posedge i_clk or posedge i_nrst) begin
    if (i_nrst) r_done <= 1'b0;
    else        r_done <= 1'b1;
  end

`else

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_SIZE - 1);

  logic              w_valid;
  logic [7:0]        w_data;
  logic              w_ferr;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_done;

  ice51_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_rx       (i_uart_rx),
    .o_valid    (w_valid),
    .o_data     (w_data),
    .o_frame_err(w_ferr)
  );

  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_done      = r_done;
  assign o_frame_err = w_ferr;

  // Address holds at LAST; r_done gates any later bytes out of memory
  always_ff @(posedge i_clk or posedge i_nrst) begin
    if (i_nrst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_we <= w_valid && !r_done;
      if (w_valid && !r_done) r_wdata <= w_data;
      if (r_we) begin
        if (r_addr == LAST) r_done <= 1'b1;
        else                r_addr <= r_addr + 1'b1;
      end
    end
  end

`endif

endmodule

// File: tb/tb_ice51_uart_loader.sv
// Randomised bench for ice51_uart_loader against a queue-based load model.
module tb_ice51_uart_loader;

  localparam int CB  = 16;
  localparam int MEM = 8;
  localparam int AW  = 3;

  logic          clk = 1'b0;
  logic          i_nrst = 1'b1;
  logic          rx = 1'b1;
  logic          we;
  logic [AW-1:0] addr;
  logic [7:0]    wdata;
  logic          done;
  logic          ferr;

  ice51_uart_loader #(
    .CLKS_PER_BIT(CB),
    .MEM_SIZE    (MEM),
    .ADDR_W      (AW)
  ) dut (
    .i_clk      (clk),
    .i_nrst     (i_nrst),
    .i_uart_rx  (rx),
    .o_mem_we   (we),
    .o_mem_addr (addr),
    .o_mem_wdata(wdata),
    .o_done     (done),
    .o_frame_err(ferr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int  a;
    int  d;
    bit  last;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_cnt = 0;
  bit   m_done = 0;
  int   ferr_exp = 0;
  int   ferr_seen = 0;
  int   wcnt = 0;
  int   last_a = -1;
  int   last_d = -1;
  bit   prev_ferr = 0;

  always @(negedge clk) begin
    if (!i_nrst) begin
      n_vec++;
      if (done !== m_done) begin
        n_err++;
        $display("FAIL done: got %b want %b at %0t", done, m_done, $time);
      end
      if (ferr === 1'b1) begin
        ferr_seen++;
        if (prev_ferr) begin
          n_err++;
          $display("FAIL ferr_width: frame_err high 2 cycles at %0t", $time);
        end
      end
      prev_ferr = (ferr === 1'b1);
      if (we !== 1'b0) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_we: addr %0d data %h at %0t", addr, wdata, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (int'(addr) != e.a || int'(wdata) != e.d) begin
            n_err++;
            $display("FAIL write: got %0d/%h want %0d/%h", addr, wdata, e.a, e.d);
          end
          if (e.last) m_done = 1;
        end
        wcnt++;
        last_a = int'(addr);
        last_d = int'(wdata);
      end
    end else begin
      prev_ferr = 0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_nrst = 1'b1;
    rx = 1'b1;
    q.delete();
    m_cnt = 0;
    m_done = 0;
    ferr_exp = 0;
    ferr_seen = 0;
    wcnt = 0;
    hold(1'b1, 3);
    chk("reset_outs", {we, addr, wdata, done, ferr}, 0);
    i_nrst = 1'b0;
    hold(1'b1, CB);
  endtask

  task automatic send(input logic [7:0] d, input bit ok, input int gap);
    if (ok && m_cnt < MEM) begin
      q.push_back('{a: m_cnt, d: int'(d), last: (m_cnt == MEM - 1)});
      m_cnt++;
    end
    if (!ok) ferr_exp++;
    hold(1'b0, CB);
    for (int i = 0; i < 8; i++) hold(d[i], CB);
    hold(ok, CB);
    if (!ok) hold(1'b1, CB);
    hold(1'b1, gap);
    chk("pending_writes", q.size(), 0);
    chk("ferr_count", ferr_seen, ferr_exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ICE51_LOADER_BYPASS_EN
    rx = 1'b1;
    hold(1'b1, 3);
    chk("byp_reset_done", done, 0);
    i_nrst = 1'b0;
    @(posedge clk);
    #1;
    m_done = 1;
    chk("byp_done", done, 1);
    hold(1'b0, CB);
    for (int i = 0; i < 8; i++) hold(i[0], CB);
    hold(1'b1, 2 * CB);
    chk("byp_no_we", wcnt, 0);
    chk("byp_no_ferr", ferr_seen, 0);
`else
    // single byte
    do_reset();
    send(8'hA5, 1, CB);
    chk("t1_wcnt", wcnt, 1);
    chk("t1_addr", last_a, 0);
    chk("t1_data", last_d, 8'hA5);
    chk("t1_done", done, 0);

    // full load, then ignored byte
    do_reset();
    for (int i = 1; i <= MEM; i++) send(8'(i), 1, 0);
    hold(1'b1, 2);
    chk("t2_done", done, 1);
    chk("t2_last_addr", last_a, MEM - 1);
    chk("t2_last_data", last_d, MEM);
    send(8'hFF, 1, CB);
    chk("t2_no_we", wcnt, MEM);
    chk("t2_done_hold", done, 1);

    // frame error then good byte at the same address
    do_reset();
    send(8'h3C, 0, CB);
    chk("t3_ferr", ferr_seen, 1);
    chk("t3_no_we", wcnt, 0);
    send(8'h11, 1, CB);
    chk("t3_addr", last_a, 0);
    chk("t3_data", last_d, 8'h11);

    // short low glitch rejected
    hold(1'b0, CB / 4);
    hold(1'b1, CB);
    chk("t4_no_we", wcnt, 1);
    chk("t4_no_ferr", ferr_seen, 1);
    send(8'h77, 1, 0);
    chk("t4_after_addr", last_a, 1);

    // reset during data bit 4
    do_reset();
    send(8'h01, 1, 0);
    hold(1'b0, CB);
    for (int i = 0; i < 4; i++) hold(1'b1, CB);
    hold(1'b0, CB / 2);
    do_reset();
    send(8'h5A, 1, CB);
    chk("t5_addr", last_a, 0);
    chk("t5_data", last_d, 8'h5A);

    // random traffic across two loads
    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int k = 0; k < 14; k++) begin
        logic [7:0] d;
        bit ok;
        int gap;
        d = 8'($urandom);
        ok = ($urandom_range(0, 5) != 0);
        gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 2 * CB));
        send(d, ok, gap);
      end
      hold(1'b1, 2);
      chk("rnd_done", done, (m_cnt >= MEM) ? 1 : 0);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
